memcache_key_packer: RTL
========================

// Module: memcache_key_packer
// PURPOSE
//  Packs a memcache key byte stream from the protocol parser into one 96-bit hash block
//  {k0,k1,k2} plus key_length, the operand format consumed by the lookup3 hash pipeline.
//  Sits between the request parser and the hash stage; one key per output beat.
//  First key byte lands in k0[31:24]. Unused tail bytes are zero.
// PARAMETERS
//  MAX_KEY_LEN  12  bytes packed per key; legal range 1..12; bytes beyond are overlong
//  LEN_W        8   width of key_length and the internal byte counter
// PORTS
//  CLK         in   1      clock; all state updates on rising edge
//  RST         in   1      reset, asynchronous assert, active-low (0 = reset)
//  in_valid    in   1      key byte valid
//  in_data     in   8      key byte, in key order
//  in_last     in   1      marks final byte of current key
//  in_ready    out  1      packer accepts byte this cycle
//  out_valid   out  1      {key_length,k0,k1,k2} valid
//  out_ready   in   1      downstream takes block; tie to 1 for a free-running hash pipe
//  key_length  out  LEN_W  bytes in key (see overlong rules)
//  k0,k1,k2    out  32     packed key words, big-endian byte order
//  key_drop    out  1      one-cycle pulse, overlong key discarded (KEY_LEN_CHECK_EN only)
// BEHAVIOUR
//  Reset (RST=0, any time, mid-key included): state=ACC, count=0, k0..k2=0,
//   key_length=0, out_valid=0, key_drop=0, in_ready=0 while RST low.
//   Partial key is lost; the next accepted byte starts a new key.
//  Byte accepted when in_valid&in_ready.
//  States:
//   ACC: in_ready=1. Byte i (0-based) goes to byte lane i: word i/4, bits [31-8*(i%4) -: 8].
//    Lanes only written while i<MAX_KEY_LEN. count saturates at 2^LEN_W-1.
//    in_last accepted -> HOLD; overlong byte with macro on -> DISCARD.
//   HOLD: in_ready=0, out_valid=1, outputs stable.
//    out_ready=1 -> ACC; words cleared to 0, count=0, out_valid=0 next cycle.
//   DISCARD: in_ready=1; bytes consumed, nothing stored. in_last accepted -> ACC,
//    words/count cleared, key_drop=1 for that cycle.
//  Latency: out_valid rises the cycle after the in_last beat is accepted.
//   Throughput: one key per (len+1) cycles when out_ready=1.
//  key_length = count including the last byte (1..2^LEN_W-1).
//  Zero-length keys cannot occur: in_last always marks a byte.
//  in_valid with in_ready=0: byte is not taken; the source holds it.
//  out_ready while out_valid=0: ignored.
// CONFIGURATION
//  KEY_LEN_CHECK_EN defined:
//   - Byte index MAX_KEY_LEN (the 13th byte at default) enters DISCARD.
//   - If that byte also carries in_last: key_drop pulses and state returns to ACC.
//   - The key produces no out_valid.
//  KEY_LEN_CHECK_EN undefined:
//   - key_drop tied 0; DISCARD unreachable.
//   - Overlong keys are truncated to the first MAX_KEY_LEN bytes.
//   - key_length still reports the full, saturated byte count.
// TESTING
//  1 "abcde", out_ready=1 -> next cycle out_valid=1, key_length=5,
//    k0=61626364, k1=65000000, k2=00000000.
//  2 "abcdefghijkl" -> key_length=12 (0x0c), k0=61626364, k1=65666768, k2=696a6b6c.
//  3 Single byte "z" with in_last, out_ready=0 for 5 cycles ->
//    out_valid held, in_ready=0, k0=7a000000; then one ready cycle -> out_valid=0, in_ready=1.
//  4 RST low after 3 bytes of "abcdef" -> outputs 0 immediately.
//    "xy" sent after release -> k0=78790000, key_length=2.
//  5 14-byte "abcdefghijklmn", macro on -> no out_valid, key_drop=1 on last byte.
//    Following "q" packs to k0=71000000, key_length=1.
//  6 Same 14-byte key, macro off -> key_length=14 (0x0e), k2=696a6b6c, key_drop=0.

Source files
------------

// File: rtl/memcache_key_packer.sv
// memcache_key_packer: packs a key byte stream into a lookup3 {k0,k1,k2} block.
// Optional macro KEY_LEN_CHECK_EN: drop keys longer than MAX_KEY_LEN, pulse key_drop.
module memcache_key_packer #(
    parameter int MAX_KEY_LEN = 12,
    parameter int LEN_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] key_length,
    output logic [31:0]      k0,
    output logic [31:0]      k1,
    output logic [31:0]      k2,
    output logic             key_drop
);

    localparam int NLANE = 12;

    typedef enum logic [1:0] {
        S_ACC,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   count;
    logic [8*NLANE-1:0] blk;
    logic               take;
    logic [LEN_W-1:0]   count_inc;

    // in_ready is forced low while reset is held, even though state reads ACC
    assign in_ready   = RST & (state != S_HOLD);
    assign take       = in_valid & in_ready;
    assign count_inc  = (&count) ? count : count + LEN_W'(1);
    assign key_length = count;
    assign k0         = blk[95:64];
    assign k1         = blk[63:32];
    assign k2         = blk[31:0];

`ifdef KEY_LEN_CHECK_EN
    logic drop_q;
    logic overlong;

    assign key_drop = drop_q;
    assign overlong = (count >= LEN_W'(MAX_KEY_LEN));
`else
    assign key_drop = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_ACC;
            count     <= '0;
            blk       <= '0;
            out_valid <= 1'b0;
`ifdef KEY_LEN_CHECK_EN
            drop_q    <= 1'b0;
`endif
        end else begin
`ifdef KEY_LEN_CHECK_EN
            drop_q <= 1'b0;
`endif
            unique case (state)
                S_ACC: begin
                    if (take) begin
`ifdef KEY_LEN_CHECK_EN
                        if (overlong) begin
                            if (in_last) begin
                                drop_q <= 1'b1;
                                count  <= '0;
                                blk    <= '0;
                            end else begin
                                state  <= S_DISCARD;
                            end
                        end else
`endif
                        begin
                            // bytes past MAX_KEY_LEN are counted but not stored
                            for (int i = 0; i < NLANE; i++) begin
                                if (i < MAX_KEY_LEN && count == LEN_W'(i))
                                    blk[8*NLANE-1-8*i -: 8] <= in_data;
                            end
                            count <= count_inc;
                            if (in_last) begin
                                state     <= S_HOLD;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_ACC;
                        out_valid <= 1'b0;
                        count     <= '0;
                        blk       <= '0;
                    end
                end
                S_DISCARD: begin
`ifdef KEY_LEN_CHECK_EN
                    if (take && in_last) begin
                        state  <= S_ACC;
                        drop_q <= 1'b1;
                        count  <= '0;
                        blk    <= '0;
                    end
`else
                    state <= S_ACC;
`endif
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule
